// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared definitions for the TDC interval capture block:
//                measurement FSM state encoding and result record layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    // Result record is {err, to, count[CNT_W-1:0]}
    function automatic int rec_err_bit(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int rec_to_bit(input int cnt_w);
        return cnt_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_result_fifo
//  Description : Synchronous first-word-fall-through FIFO for measurement
//                records. A push into a full FIFO is accepted only when a
//                pop happens in the same cycle.
//  Ports       : clk, reset_n (async, active low), clr (sync flush),
//                push/push_data, pop/pop_data (head record, 0 when empty),
//                full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_result_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic             do_pop;
    logic             do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdc_interval_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_interval_capture
//  Description : Measures the coarse interval in clk cycles between a TDC
//                start edge and the following stop, checks the generator's
//                done pulse, and queues {err, to, count} records in a FWFT
//                FIFO with valid/ready readout.
//  Ports       : clk, reset_n (async, active low)
//                tdc_start, tdc_stop, done   - generator interface
//                clr                         - sync flush / return to idle
//                rd_ready, rd_valid, rd_data - record readout
//                busy                        - measurement in progress
//                drop_flag                   - sticky record-lost flag
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_interval_capture
    import tdc_pkg::*;
#(
    parameter int             CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(16'hFFF0),
    parameter int             FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tdc_start,
    input  logic             tdc_stop,
    input  logic             done,
    input  logic             clr,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [CNT_W+1:0] rd_data,
    output logic             busy,
    output logic             drop_flag
);

    localparam int RW    = CNT_W + 2;
    localparam int ERR_B = rec_err_bit(CNT_W);
    localparam int TO_B  = rec_to_bit(CNT_W);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_d_q;
    logic [RW-1:0]     rec_q;
    logic              drop_q;

    logic              start_evt;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop_d;

    // A held-high start only counts once, on its rising edge
    assign start_evt = tdc_start & ~start_d_q;

    assign push   = (state_q == ST_PUSH);
    assign pop    = rd_valid & rd_ready;
    assign drop_d = push & fifo_full & ~pop;

    assign rd_valid  = ~fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign drop_flag = drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            start_d_q <= 1'b0;
            rec_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            start_d_q <= tdc_start;
            if (clr) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                drop_q  <= 1'b0;
            end else begin
                if (drop_d) begin
                    drop_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        // Stop is ignored here, so start wins when both arrive
                        if (start_evt) begin
                            state_q <= ST_RUN;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        // Generator ORs stop into start, so start is not watched here
                        if (tdc_stop) begin
                            state_q            <= ST_CHECK;
                            rec_q              <= '0;
                            rec_q[CNT_W-1:0]   <= cnt_q;
                        end else if (cnt_q == MAX_CYCLES) begin
                            // Timeout test comes before the increment, so no wrap
                            state_q            <= ST_PUSH;
                            rec_q              <= '0;
                            rec_q[CNT_W-1:0]   <= cnt_q;
                            rec_q[TO_B]        <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        // done must arrive exactly one cycle after the stop
                        rec_q[ERR_B] <= ~done;
                        state_q      <= ST_PUSH;
                    end
                    ST_PUSH: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    tdc_result_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .push      (push),
        .push_data (rec_q),
        .pop       (pop),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire
